// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the sequential ALU.
//   - opcode encodings (opcode_e), OPCODE_W opcode field width
//   - FSM state encoding (state_e: IDLE / BUSY / DONE)
//   - cnt_width(): width of the iterative step counter for a given data width
package ula_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_AND  = 4'd4,
        OP_NAND = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_CMP  = 4'd8,
        OP_NOT  = 4'd9,
        OP_LFSR = 4'd10
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter must be able to hold the value n (steps remaining).
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ula_muldiv.sv
// ula_muldiv: iterative unsigned multiplier / divider sharing one accumulator.
//   clk, rst     clock, asynchronous active-high reset
//   start        load a/b/is_div and perform the first step in the same cycle
//   is_div       0: shift-add multiply, 1: restoring divide
//   a, b         operands (multiplier/multiplicand or dividend/divisor)
//   done         result available on lo/hi (held until the next start)
//   lo, hi       MUL: product low/high half; DIV: quotient/remainder
// Takes W steps in total; done rises W-1 cycles after the start cycle.
module ula_muldiv
    import ula_pkg::*;
#(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         is_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi
);

    localparam int CW = cnt_width(W);

    logic [2*W-1:0] acc_q, acc_d, acc_src, acc_step;
    logic [W-1:0]   b_q, b_d, b_sel;
    logic           is_div_q, is_div_d, div_sel;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           active_q, active_d;
    logic [W:0]     add_sum, rem_sh, rem_diff;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        acc_d    = acc_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        cnt_d    = cnt_q;
        active_d = active_q;

        // On start the first step operates on the fresh operands directly.
        acc_src = start ? {{W{1'b0}}, a} : acc_q;
        b_sel   = start ? b : b_q;
        div_sel = start ? is_div : is_div_q;

        // Multiply: conditionally add b into the upper half, then shift right.
        add_sum = {1'b0, acc_src[2*W-1:W]} + (acc_src[0] ? {1'b0, b_sel} : {(W+1){1'b0}});

        // Divide: remainder shifted left with the next dividend bit; keep the
        // difference only if it did not go negative.
        rem_sh   = acc_src[2*W-1:W-1];
        rem_diff = rem_sh - {1'b0, b_sel};

        if (div_sel) begin
            if (rem_sh >= {1'b0, b_sel}) begin
                acc_step = {rem_diff[W-1:0], acc_src[W-2:0], 1'b1};
            end else begin
                acc_step = {rem_sh[W-1:0], acc_src[W-2:0], 1'b0};
            end
        end else begin
            acc_step = {add_sum, acc_src[W-1:1]};
        end

        if (start) begin
            acc_d    = acc_step;
            b_d      = b;
            is_div_d = is_div;
            cnt_d    = CW'(W - 1);
            active_d = 1'b1;
        end else if (active_q) begin
            if (cnt_q != '0) begin
                acc_d = acc_step;
                cnt_d = cnt_q - 1'b1;
            end else begin
                active_d = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign done = active_q && (cnt_q == '0);
    assign lo   = acc_q[W-1:0];
    assign hi   = acc_q[2*W-1:W];

endmodule

// File: rtl/ula_seq.sv
// ula_seq: sequential ALU with valid/ready handshakes and registered results.
//   clk, rst               clock, asynchronous active-high reset
//   in_valid / in_ready    operation handshake (accepted only in IDLE)
//   operand_a, operand_b   DATA_SIZE-bit operands
//   opcode                 operation select (see ula_pkg::opcode_e; 11..15 illegal)
//   out_valid / out_ready  result handshake (held in DONE until out_ready)
//   out, out_hi            primary result; MUL high half / DIV remainder
//   flag_zero/carry/ovf/err status flags, registered together with the result
module ula_seq
    import ula_pkg::*;
#(
    parameter int                   DATA_SIZE = 11,
    parameter logic [DATA_SIZE-1:0] LFSR_TAPS = 11'h500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_SIZE-1:0]  operand_a,
    input  logic [DATA_SIZE-1:0]  operand_b,
    input  logic [OPCODE_W-1:0]   opcode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_SIZE-1:0]  out,
    output logic [DATA_SIZE-1:0]  out_hi,
    output logic                  flag_zero,
    output logic                  flag_carry,
    output logic                  flag_ovf,
    output logic                  flag_err
);

    localparam int W = DATA_SIZE;

    state_e         state_q, state_d;
    logic [W-1:0]   out_q, out_d, out_hi_q, out_hi_d;
    logic           zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, err_q, err_d;
    logic           op_div_q, op_div_d;

    logic [W-1:0]   res_out, res_hi;
    logic           res_c, res_v, res_e;
    logic [W:0]     add_w;
    logic           iterative, load, md_start, md_done;
    logic [W-1:0]   md_lo, md_hi;

    ula_muldiv #(.W(W)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .is_div (opcode == OP_DIV),
        .a      (operand_a),
        .b      (operand_b),
        .done   (md_done),
        .lo     (md_lo),
        .hi     (md_hi)
    );

    // Single-cycle datapath, evaluated straight off the inputs at accept time.
    always_comb begin
        res_out = '0;
        res_hi  = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_e   = 1'b0;
        add_w   = {1'b0, operand_a} + {1'b0, operand_b};
        case (opcode)
            OP_ADD: begin
                res_out = add_w[W-1:0];
                res_c   = add_w[W];
                res_v   = (operand_a[W-1] == operand_b[W-1]) && (res_out[W-1] != operand_a[W-1]);
            end
            OP_SUB: begin
                res_out = operand_a - operand_b;
                res_c   = operand_a < operand_b;
                res_v   = (operand_a[W-1] != operand_b[W-1]) && (res_out[W-1] != operand_a[W-1]);
            end
            OP_MUL: ; // iterative path only
            OP_DIV: begin
                // Only reached here for a zero divisor.
                res_out = '1;
                res_hi  = operand_a;
                res_e   = 1'b1;
            end
            OP_AND:  res_out = operand_a & operand_b;
            OP_NAND: res_out = ~(operand_a & operand_b);
            OP_OR:   res_out = operand_a | operand_b;
            OP_XOR:  res_out = operand_a ^ operand_b;
            OP_CMP: begin
                if (operand_a > operand_b)       res_out = {{(W-1){1'b0}}, 1'b1};
                else if (operand_a == operand_b) res_out = '0;
                else                             res_out = '1;
            end
            OP_NOT:  res_out = ~operand_a;
            OP_LFSR: res_out = {operand_a[W-2:0], ^(operand_a & LFSR_TAPS)};
            default: res_e = 1'b1;
        endcase
    end

    assign iterative = (opcode == OP_MUL) || ((opcode == OP_DIV) && (operand_b != '0));

    // FSM next state and result registers; results load only on entry to DONE.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        out_hi_d = out_hi_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        op_div_d = op_div_q;
        md_start = 1'b0;
        load     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (iterative) begin
                        md_start = 1'b1;
                        op_div_d = (opcode == OP_DIV);
                        state_d  = ST_BUSY;
                    end else begin
                        out_d    = res_out;
                        out_hi_d = res_hi;
                        carry_d  = res_c;
                        ovf_d    = res_v;
                        err_d    = res_e;
                        load     = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    out_d    = md_lo;
                    out_hi_d = md_hi;
                    carry_d  = !op_div_q && (md_hi != '0);
                    ovf_d    = 1'b0;
                    err_d    = 1'b0;
                    load     = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                // Handoff cycle: no new accept until back in IDLE.
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) zero_d = (out_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            out_q    <= '0;
            out_hi_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            op_div_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            out_hi_q <= out_hi_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            op_div_q <= op_div_d;
        end
    end

    assign in_ready   = (state_q == ST_IDLE);
    assign out_valid  = (state_q == ST_DONE);
    assign out        = out_q;
    assign out_hi     = out_hi_q;
    assign flag_zero  = zero_q;
    assign flag_carry = carry_q;
    assign flag_ovf   = ovf_q;
    assign flag_err   = err_q;

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed, table-driven bench for ula_seq (DATA_SIZE = 11).
module tb_ula_seq;
    import ula_pkg::*;

    localparam int W = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  operand_a;
    logic [W-1:0]  operand_b;
    logic [3:0]    opcode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out;
    logic [W-1:0]  out_hi;
    logic          flag_zero, flag_carry, flag_ovf, flag_err;

    int total = 0;
    int bad   = 0;

    ula_seq #(.DATA_SIZE(W), .LFSR_TAPS(11'h500)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .opcode     (opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .out_hi     (out_hi),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .flag_ovf   (flag_ovf),
        .flag_err   (flag_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_out;
        logic [W-1:0] exp_hi;
        logic         z, c, v, e;
        int           lat;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    function automatic vec_t mk(input logic [3:0] op, input int a, input int b,
                                input int o, input int h, input logic z, input logic c,
                                input logic v, input logic e, input int lat);
        vec_t r;
        r.op = op; r.a = W'(a); r.b = W'(b); r.exp_out = W'(o); r.exp_hi = W'(h);
        r.z = z; r.c = c; r.v = v; r.e = e; r.lat = lat;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Present an op at a negedge once in_ready is high; returns #1 after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready wait timeout", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        opcode    = op;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Latency counted with the accept edge as cycle 1.
    task automatic wait_valid(output int lat, output logic saw_ready);
        lat = 1;
        saw_ready = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) saw_ready = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int   lat;
        logic saw;

        vecs[0]  = mk(OP_ADD,  2000, 100, 52,    0,    0, 1, 0, 0, 1);
        vecs[1]  = mk(OP_SUB,  3,    5,   2046,  0,    0, 1, 0, 0, 1);
        vecs[2]  = mk(OP_MUL,  45,   50,  202,   1,    0, 1, 0, 0, 12);
        vecs[3]  = mk(OP_DIV,  1000, 7,   142,   6,    0, 0, 0, 0, 12);
        vecs[4]  = mk(OP_DIV,  1000, 0,   2047,  1000, 0, 0, 0, 1, 1);
        vecs[5]  = mk(OP_CMP,  5,    9,   2047,  0,    0, 0, 0, 0, 1);
        vecs[6]  = mk(OP_NAND, 'h0F0, 'h0FF, 'h70F, 0, 0, 0, 0, 0, 1);
        vecs[7]  = mk(OP_LFSR, 'h400, 0,  'h001, 0,    0, 0, 0, 0, 1);
        vecs[8]  = mk(OP_LFSR, 'h001, 0,  'h002, 0,    0, 0, 0, 0, 1);
        vecs[9]  = mk(4'd12,   1,    2,   0,     0,    1, 0, 0, 1, 1);
        vecs[10] = mk(OP_ADD,  1023, 1,   1024,  0,    0, 0, 1, 0, 1);
        vecs[11] = mk(OP_SUB,  1024, 1,   1023,  0,    0, 0, 1, 0, 1);
        vecs[12] = mk(OP_XOR,  'h555, 'h555, 0,  0,    1, 0, 0, 0, 1);
        vecs[13] = mk(OP_CMP,  9,    5,   1,     0,    0, 0, 0, 0, 1);
        vecs[14] = mk(OP_CMP,  7,    7,   0,     0,    1, 0, 0, 0, 1);
        vecs[15] = mk(OP_NOT,  'h0F0, 'h3FF, 'h70F, 0, 0, 0, 0, 0, 1);
        vecs[16] = mk(OP_MUL,  2047, 2047, 1,    2046, 0, 1, 0, 0, 12);
        vecs[17] = mk(OP_DIV,  5,    9,   0,     5,    1, 0, 0, 0, 12);
        vecs[18] = mk(OP_LFSR, 0,    0,   0,     0,    1, 0, 0, 0, 1);
        vecs[19] = mk(OP_AND,  'h0F0, 'h0FF, 'h0F0, 0, 0, 0, 0, 0, 1);
        vecs[20] = mk(OP_OR,   'h0F0, 'h00F, 'h0FF, 0, 0, 0, 0, 0, 1);
        vecs[21] = mk(4'd15,   7,    7,   0,     0,    1, 0, 0, 1, 1);
        vecs[22] = mk(OP_MUL,  0,    123, 0,     0,    1, 0, 0, 0, 12);
        vecs[23] = mk(OP_ADD,  2047, 1,   0,     0,    1, 1, 0, 0, 1);

        // Reset state.
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; operand_a = '0; operand_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 0);
        check("reset out", 32'(out), 0);
        check("reset flags", {28'd0, flag_zero, flag_carry, flag_ovf, flag_err}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post-reset in_ready", 32'(in_ready), 1);

        // Table-driven vectors.
        for (int i = 0; i < NV; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_valid(lat, saw);
            check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d out", i), 32'(out), 32'(vecs[i].exp_out));
            check($sformatf("v%0d out_hi", i), 32'(out_hi), 32'(vecs[i].exp_hi));
            check($sformatf("v%0d zero", i), 32'(flag_zero), 32'(vecs[i].z));
            check($sformatf("v%0d carry", i), 32'(flag_carry), 32'(vecs[i].c));
            check($sformatf("v%0d ovf", i), 32'(flag_ovf), 32'(vecs[i].v));
            check($sformatf("v%0d err", i), 32'(flag_err), 32'(vecs[i].e));
            check($sformatf("v%0d in_ready low while busy/done", i), 32'(saw | in_ready), 0);
            release_result();
            check($sformatf("v%0d handoff out_valid", i), 32'(out_valid), 0);
        end

        // Backpressure: results held, new op ignored until after the handoff.
        issue(OP_ADD, 11'd7, 11'd8);
        wait_valid(lat, saw);
        check("bp first out", 32'(out), 15);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1; opcode = OP_XOR; operand_a = 11'd3; operand_b = 11'd5;
            @(posedge clk);
            #1;
            check($sformatf("bp hold%0d out_valid", k), 32'(out_valid), 1);
            check($sformatf("bp hold%0d out", k), 32'(out), 15);
            check($sformatf("bp hold%0d in_ready", k), 32'(in_ready), 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp handoff out_valid", 32'(out_valid), 0);
        check("bp handoff in_ready", 32'(in_ready), 1);
        check("bp handoff out held", 32'(out), 15);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp second accepted", 32'(out_valid), 1);
        check("bp second out", 32'(out), 6);
        release_result();

        // Reset in the middle of a MUL, with nonzero flags left over from an illegal op.
        issue(4'd13, 11'd1, 11'd1);
        wait_valid(lat, saw);
        check("pre-rst err", 32'(flag_err), 1);
        release_result();
        issue(OP_MUL, 11'd45, 11'd50);
        repeat (4) @(posedge clk);
        #1;
        check("mid-mul busy", 32'(in_ready | out_valid), 0);
        rst = 1'b1;
        #1;
        check("rst out_valid", 32'(out_valid), 0);
        check("rst flags", {28'd0, flag_zero, flag_carry, flag_ovf, flag_err}, 0);
        check("rst out", 32'(out), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("after rst in_ready", 32'(in_ready), 1);
        check("after rst out_valid", 32'(out_valid), 0);
        issue(OP_ADD, 11'd1, 11'd1);
        wait_valid(lat, saw);
        check("after rst add latency", 32'(lat), 1);
        check("after rst add out", 32'(out), 2);
        check("after rst add hi", 32'(out_hi), 0);
        release_result();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
